// File: rtl/mainfsm_ext_if.sv
// Control-bus bundle between instruction decoder, memory/multiplier handshakes
// and the datapath controls driven by mainfsm_ext.
interface mainfsm_ext_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IsMul;
    logic       IsLink;
    logic       MemReady;
    logic       MulDone;

    logic       IRWrite;
    logic       AdrSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       MemReq;
    logic       MulStart;
    logic       LinkW;
    logic       Fault;
    logic [3:0] State;

    // Environment side: supplies decode fields and handshakes, observes controls.
    modport master (
        output Op, Funct, IsMul, IsLink, MemReady, MulDone,
        input  IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
        input  ALUSrcA, ALUSrcB, ResultSrc, MemReq, MulStart, LinkW, Fault, State
    );

    // Controller side.
    modport slave (
        input  Op, Funct, IsMul, IsLink, MemReady, MulDone,
        output IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
        output ALUSrcA, ALUSrcB, ResultSrc, MemReq, MulStart, LinkW, Fault, State
    );
endinterface

// File: rtl/mainfsm_ext.sv
// Multicycle main control FSM with memory wait states, multiply path,
// branch-with-link and a stall watchdog that traps into a sticky FAULT state.
module mainfsm_ext #(
    parameter logic        WAIT_EN  = 1'b1,
    parameter logic        MUL_EN   = 1'b1,
    parameter int unsigned WDOG_W   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic         clk,
    input logic         reset,
    mainfsm_ext_if.slave bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        MULSTART = 4'd10,
        MULWAIT  = 4'd11,
        MULWB    = 4'd12,
        FAULT    = 4'd13
    } state_t;

    localparam logic [WDOG_W-1:0] MAX_W = WDOG_W'(MAX_WAIT);

    state_t            state;
    state_t            nxt;
    logic [WDOG_W-1:0] wcnt;
    logic              fault_q;
    logic              ready;
    logic              stall;
    logic              unused_funct;

    assign unused_funct = ^bus.Funct[4:1];

    always_comb begin
        ready = (WAIT_EN != 1'b0) ? bus.MemReady : 1'b1;
    end

    always_comb begin
        nxt   = state;
        stall = 1'b0;
        case (state)
            FETCH: begin
                stall = !ready;
                if (ready) nxt = DECODE;
            end
            DECODE: begin
                case (bus.Op)
                    2'b00: begin
                        if (bus.IsMul && (MUL_EN != 1'b0)) nxt = MULSTART;
                        else if (bus.IsMul)                nxt = FAULT;
                        else if (bus.Funct[5])             nxt = EXECUTEI;
                        else                               nxt = EXECUTER;
                    end
                    2'b01:   nxt = MEMADR;
                    2'b10:   nxt = BRANCH;
                    default: nxt = FAULT;
                endcase
            end
            MEMADR:   nxt = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD: begin
                stall = !ready;
                if (ready) nxt = MEMWB;
            end
            MEMWR: begin
                stall = !ready;
                if (ready) nxt = FETCH;
            end
            EXECUTER, EXECUTEI:          nxt = ALUWB;
            ALUWB, MEMWB, BRANCH, MULWB: nxt = FETCH;
            MULSTART:                    nxt = MULWAIT;
            MULWAIT: begin
                stall = !bus.MulDone;
                if (bus.MulDone) nxt = MULWB;
            end
            FAULT:   nxt = FAULT;
            default: nxt = FAULT;
        endcase
        // A completing handshake on the limit cycle clears stall, so it wins.
        if (stall && (wcnt == MAX_W)) nxt = FAULT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            wcnt    <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)
                wcnt <= '0;
            else if (stall && (wcnt != '1))
                wcnt <= wcnt + 1'b1;
            if (nxt == FAULT)
                fault_q <= 1'b1;
        end
    end

    // Controls are decoded from state plus live handshakes and gated by the
    // asynchronous reset, so an aborted access drops its strobes immediately.
    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        bus.ALUOp     = 1'b0;
        bus.ALUSrcA   = '0;
        bus.ALUSrcB   = '0;
        bus.ResultSrc = '0;
        bus.MemReq    = 1'b0;
        bus.MulStart  = 1'b0;
        bus.LinkW     = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    bus.MemReq    = 1'b1;
                    bus.IRWrite   = ready;
                    bus.NextPC    = ready;
                    bus.ALUSrcA   = 2'b01;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                end
                DECODE: begin
                    bus.ALUSrcA   = 2'b01;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                end
                EXECUTER: bus.ALUOp = 1'b1;
                EXECUTEI: begin
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = 1'b1;
                end
                ALUWB: bus.RegW = 1'b1;
                MEMADR: bus.ALUSrcB = 2'b01;
                MEMRD: begin
                    bus.MemReq = 1'b1;
                    bus.AdrSrc = 1'b1;
                end
                MEMWR: begin
                    bus.MemReq = 1'b1;
                    bus.AdrSrc = 1'b1;
                    bus.MemW   = 1'b1;
                end
                MEMWB: begin
                    bus.RegW      = 1'b1;
                    bus.ResultSrc = 2'b01;
                end
                BRANCH: begin
                    bus.Branch    = 1'b1;
                    bus.ALUSrcB   = 2'b01;
                    bus.ResultSrc = 2'b10;
                    bus.LinkW     = bus.IsLink;
                end
                MULSTART: bus.MulStart = 1'b1;
                MULWB: begin
                    bus.RegW      = 1'b1;
                    bus.ResultSrc = 2'b11;
                end
                default: ;
            endcase
        end
        bus.Fault = reset & fault_q;
        bus.State = reset ? state : '0;
    end

endmodule

// File: tb/tb_mainfsm_ext.sv
// Directed bench for mainfsm_ext: instruction sequences, wait states, watchdog
// trap, multiply path (enabled and disabled) and mid-access reset.
module tb_mainfsm_ext;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mainfsm_ext_if bus ();
    mainfsm_ext_if bus2 ();

    mainfsm_ext #(.WAIT_EN(1'b1), .MUL_EN(1'b1), .WDOG_W(4), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mainfsm_ext #(.WAIT_EN(1'b1), .MUL_EN(1'b0), .WDOG_W(4), .MAX_WAIT(15)) dut_nomul (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (got running, expected finished)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] funct,
                         input logic mul, input logic link);
        bus.Op     = op;
        bus.Funct  = funct;
        bus.IsMul  = mul;
        bus.IsLink = link;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk("rst_state", bus.State, 0);
        chk("rst_fault", bus.Fault, 0);
        chk("rst_memreq", bus.MemReq, 0);
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        instr(2'b00, 6'b000100, 1'b0, 1'b0);
        bus.MemReady  = 1'b1;
        bus.MulDone   = 1'b0;
        bus2.Op       = 2'b00;
        bus2.Funct    = 6'b000000;
        bus2.IsMul    = 1'b0;
        bus2.IsLink   = 1'b0;
        bus2.MemReady = 1'b1;
        bus2.MulDone  = 1'b0;

        // Reset state: outputs forced low
        tick(); tick();
        chk("reset_state", bus.State, 0);
        chk("reset_fault", bus.Fault, 0);
        chk("reset_memreq", bus.MemReq, 0);
        chk("reset_irwrite", bus.IRWrite, 0);
        reset = 1'b1;
        #1;

        // ADD register: 0,1,6,8,0
        chk("add_fetch_st", bus.State, 0);
        chk("add_fetch_memreq", bus.MemReq, 1);
        chk("add_fetch_irw", bus.IRWrite, 1);
        chk("add_fetch_npc", bus.NextPC, 1);
        chk("add_fetch_srca", bus.ALUSrcA, 2'b01);
        chk("add_fetch_srcb", bus.ALUSrcB, 2'b10);
        chk("add_fetch_res", bus.ResultSrc, 2'b10);
        tick();
        chk("add_dec_st", bus.State, 1);
        chk("add_dec_irw", bus.IRWrite, 0);
        chk("add_dec_npc", bus.NextPC, 0);
        tick();
        chk("add_exe_st", bus.State, 6);
        chk("add_exe_aluop", bus.ALUOp, 1);
        chk("add_exe_regw", bus.RegW, 0);
        tick();
        chk("add_wb_st", bus.State, 8);
        chk("add_wb_regw", bus.RegW, 1);
        chk("add_wb_res", bus.ResultSrc, 2'b00);
        tick();
        chk("add_back_st", bus.State, 0);

        // Immediate data-processing goes through EXECUTEI
        instr(2'b00, 6'b100000, 1'b0, 1'b0);
        tick();
        tick();
        chk("addi_exe_st", bus.State, 7);
        chk("addi_exe_srcb", bus.ALUSrcB, 2'b01);
        tick(); tick();

        // LDR with 3 wait cycles in MEMRD
        instr(2'b01, 6'b000001, 1'b0, 1'b0);
        tick();
        chk("ldr_dec_st", bus.State, 1);
        tick();
        chk("ldr_adr_st", bus.State, 2);
        chk("ldr_adr_srcb", bus.ALUSrcB, 2'b01);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.MemReady = (i == 3);
            #1;
            chk("ldr_rd_st", bus.State, 3);
            chk("ldr_rd_memreq", bus.MemReq, 1);
            chk("ldr_rd_adrsrc", bus.AdrSrc, 1);
            tick();
        end
        chk("ldr_wb_st", bus.State, 4);
        chk("ldr_wb_regw", bus.RegW, 1);
        chk("ldr_wb_res", bus.ResultSrc, 2'b01);
        tick();
        chk("ldr_back_st", bus.State, 0);

        // STR with one wait cycle: MemW held until ready
        instr(2'b01, 6'b000000, 1'b0, 1'b0);
        tick(); tick(); tick();
        bus.MemReady = 1'b0;
        #1;
        chk("str_wr_st", bus.State, 5);
        chk("str_wr_memw", bus.MemW, 1);
        tick();
        chk("str_wr_hold_st", bus.State, 5);
        chk("str_wr_hold_memw", bus.MemW, 1);
        bus.MemReady = 1'b1;
        tick();
        chk("str_back_st", bus.State, 0);
        chk("str_back_memw", bus.MemW, 0);

        // BL then plain B
        instr(2'b10, 6'b000000, 1'b0, 1'b1);
        tick(); tick();
        chk("bl_st", bus.State, 9);
        chk("bl_branch", bus.Branch, 1);
        chk("bl_linkw", bus.LinkW, 1);
        chk("bl_res", bus.ResultSrc, 2'b10);
        tick();
        chk("bl_back_st", bus.State, 0);
        chk("bl_back_linkw", bus.LinkW, 0);
        instr(2'b10, 6'b000000, 1'b0, 1'b0);
        tick(); tick();
        chk("b_st", bus.State, 9);
        chk("b_branch", bus.Branch, 1);
        chk("b_linkw", bus.LinkW, 0);
        tick();

        // MUL: 1-cycle start pulse, 5 cycles in MULWAIT, then MULWB
        instr(2'b00, 6'b000000, 1'b1, 1'b0);
        tick(); tick();
        chk("mul_start_st", bus.State, 10);
        chk("mul_start_pulse", bus.MulStart, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.MulDone = (i == 4);
            #1;
            chk("mul_wait_st", bus.State, 11);
            chk("mul_wait_pulse", bus.MulStart, 0);
            tick();
        end
        bus.MulDone = 1'b0;
        chk("mul_wb_st", bus.State, 12);
        chk("mul_wb_regw", bus.RegW, 1);
        chk("mul_wb_res", bus.ResultSrc, 2'b11);
        tick();
        chk("mul_back_st", bus.State, 0);

        // Ready arriving on the cycle the count reaches MAX_WAIT still proceeds
        instr(2'b00, 6'b000000, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            bus.MemReady = (i == 15);
            #1;
            chk("wd_edge_st", bus.State, 0);
            chk("wd_edge_irw", bus.IRWrite, (i == 15));
            tick();
        end
        chk("wd_edge_dec_st", bus.State, 1);
        chk("wd_edge_fault", bus.Fault, 0);
        tick(); tick(); tick();
        chk("wd_edge_back_st", bus.State, 0);

        // 16 stalled FETCH cycles trap into FAULT, which is sticky
        bus.MemReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("wd_stall_st", bus.State, 0);
            tick();
        end
        chk("wd_fault_st", bus.State, 13);
        chk("wd_fault_flag", bus.Fault, 1);
        chk("wd_fault_memreq", bus.MemReq, 0);
        tick(); tick(); tick(); tick();
        bus.MemReady = 1'b1;
        tick();
        chk("wd_sticky_st", bus.State, 13);
        chk("wd_sticky_flag", bus.Fault, 1);
        pulse_reset();
        chk("wd_release_st", bus.State, 0);
        chk("wd_release_fault", bus.Fault, 0);

        // Op=11 is undefined
        instr(2'b11, 6'b000000, 1'b0, 1'b0);
        tick(); tick();
        chk("op11_st", bus.State, 13);
        chk("op11_fault", bus.Fault, 1);
        pulse_reset();

        // Reset asserted mid-MEMWR drops MemW/MemReq at once
        instr(2'b01, 6'b000000, 1'b0, 1'b0);
        tick(); tick(); tick();
        bus.MemReady = 1'b0;
        #1;
        chk("abort_pre_st", bus.State, 5);
        chk("abort_pre_memw", bus.MemW, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_memw", bus.MemW, 0);
        chk("abort_memreq", bus.MemReq, 0);
        chk("abort_st", bus.State, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("abort_release_st", bus.State, 0);
        chk("abort_release_memreq", bus.MemReq, 1);
        bus.MemReady = 1'b1;

        // MUL_EN=0: multiply decodes as undefined
        reset = 1'b0;
        bus2.IsMul = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        chk("nomul_fetch_st", bus2.State, 0);
        tick();
        chk("nomul_dec_st", bus2.State, 1);
        tick();
        chk("nomul_fault_st", bus2.State, 13);
        chk("nomul_fault_flag", bus2.Fault, 1);
        chk("nomul_no_start", bus2.MulStart, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mainfsm_ext.md
Name: mainfsm_ext

Overview:
Parametrised successor to the multicycle ARM main control FSM. It sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK with the same datapath control fields. It adds memory wait-state handshaking, a multicycle multiply path, branch-with-link, and a watchdog that traps stalls and undefined ops into a sticky FAULT state. It sits in the controller between the instruction decoder and the conditional-logic unit.

Parameters:
WAIT_EN, 1, 1 = honour MemReady; 0 = MemReady treated as constant 1
MUL_EN, 1, 1 = multiply path enabled; 0 = IsMul instructions decode as undefined (FAULT)
WDOG_W, 4, width of the wait-cycle counter
MAX_WAIT, 15, stalled cycles tolerated in one wait state; must be < 2**WDOG_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; asserted when 0
Op  in  2  instruction op field
Funct  in  6  instruction funct field (Funct[5] = I bit, Funct[0] = L/S bit)
IsMul  in  1  decoder flag: data-processing multiply
IsLink  in  1  decoder flag: branch-with-link
MemReady  in  1  memory completes the current access this cycle
MulDone  in  1  multiplier result valid
IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath controls
ALUSrcA, ALUSrcB, ResultSrc  out  2 each  mux selects (ResultSrc 11 = multiplier result)
MemReq  out  1  memory access request
MulStart  out  1  one-cycle multiplier start pulse
LinkW  out  1  write return address to R14
Fault  out  1  sticky fault flag
State  out  4  current state encoding, for debug

Behaviour:
- State register: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, MULSTART=10, MULWAIT=11, MULWB=12, FAULT=13. Codes 14–15 go to FAULT.
- While reset = 0: State = FETCH, wait counter = 0, Fault = 0. All outputs are forced to 0 combinationally, including MemReq.
- Next-state transitions:
  - FETCH -> DECODE when ready; otherwise stay in FETCH.
  - DECODE, by Op:
    - Op 00: if IsMul && MUL_EN -> MULSTART; else if IsMul -> FAULT; else Funct[5] ? EXECUTEI : EXECUTER.
    - Op 01 -> MEMADR.
    - Op 10 -> BRANCH.
    - Op 11 -> FAULT.
  - EXECUTER / EXECUTEI -> ALUWB.
  - MEMADR -> Funct[0] ? MEMRD : MEMWR.
  - MEMRD -> MEMWB when ready; MEMWR -> FETCH when ready.
  - MULSTART -> MULWAIT; MULWAIT -> MULWB when MulDone.
  - ALUWB, MEMWB, BRANCH, MULWB -> FETCH.
  - FAULT -> FAULT; exit is by reset only.
- "ready" means MemReady || !WAIT_EN.
- Outputs per state (unlisted fields are 0):
  - FETCH: MemReq=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC equal ready, so the PC advances exactly once per fetch.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - EXECUTER: ALUOp=1. EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1, ResultSrc=00. MEMADR: ALUSrcB=01.
  - MEMRD: MemReq=1, AdrSrc=1. MEMWR: MemReq=1, AdrSrc=1, MemW=1; MemW is held for every cycle until ready.
  - MEMWB: RegW=1, ResultSrc=01.
  - BRANCH: Branch=1, ALUSrcB=01, ResultSrc=10, LinkW=IsLink.
  - MULSTART: MulStart=1. MULWAIT: none. MULWB: RegW=1, ResultSrc=11.
  - FAULT: all controls 0, Fault=1.
- Watchdog:
  - Counter clears on every state change.
  - It increments each cycle spent in FETCH, MEMRD or MEMWR with !ready, or in MULWAIT with !MulDone.
  - If the count equals MAX_WAIT and the stall persists, the next state is FAULT.
  - If ready/MulDone arrives in the same cycle the count hits MAX_WAIT, the normal transition wins.
  - The counter saturates and never wraps.
- Fault is set on entry to FAULT and is held until reset.
- A mid-operation reset (e.g. during MEMWR) aborts immediately. MemW drops in the same cycle because the gating is asynchronous.
- Latency in cycles, with zero wait states: data-processing 4, LDR 5, STR 4, branch 3, multiply 4 + multiplier latency.

Test Plan:
- Reset then ADD register (Op=00, Funct=000100), MemReady=1 -> states 0,1,6,8,0. RegW=1 only in ALUWB. IRWrite/NextPC high for 1 cycle in FETCH.
- LDR (Op=01, Funct[0]=1) with MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles, MemReq=1 throughout, then MEMWB with ResultSrc=01, RegW=1.
- FETCH with MemReady low 20 cycles, MAX_WAIT=15 -> FAULT after the 16th stalled cycle, Fault=1 and sticky. reset=0 for 1 cycle -> State=0, Fault=0.
- MUL (Op=00, IsMul=1), MulDone after 5 cycles -> MulStart pulse of exactly 1 cycle, MULWAIT 5 cycles, MULWB with ResultSrc=11. Repeat with MUL_EN=0 -> FAULT from DECODE.
- BL (Op=10, IsLink=1) -> BRANCH with Branch=1 and LinkW=1 for 1 cycle. Plain B -> LinkW=0. Op=11 -> FAULT.
- STR with reset driven low mid-MEMWR -> MemW and MemReq go to 0 in the same cycle; after release, State=FETCH.
